led_shift_sender: RTL and testbench
===================================

# led_shift_sender

Parallel-to-serial transmitter for the LED shift-register display path. It accepts an 18-bit pattern and emits it one bit at a time on `n`, paced by a one-cycle `strobe` that drives the display shifter's shift clock. It also pulses `clr` to wipe the shifter before each frame. Bits go out MSB first, so once a frame completes, the receiving shifter holds the exact pattern that was loaded (pattern bit 17 ends up on display position 17).

## Interface
- `WIDTH`, default 18: pattern width; must equal the display shifter width.
- `DIV`, default 4: clocks per serial bit; legal range 3..255.
- `clk1`  in  1: system clock; all logic updates on its rising edge.
- `reset`  in  1: asynchronous, active-low reset; forces the idle state immediately.
- `load`  in  1: start request; sampled on `clk1` only while `busy`=0.
- `data`  in  WIDTH: pattern to send; captured on the cycle `load` is accepted.
- `n`  out  1: serial data bit, registered.
- `strobe`  out  1: one-cycle shift pulse for the receiver, registered.
- `clr`  out  1: active-high one-cycle clear pulse for the receiver, registered.
- `busy`  out  1: a frame is in progress, registered.
- `done`  out  1: one-cycle pulse when a frame finishes, registered.

## Operation
- Internal state:
  - `shreg[WIDTH-1:0]`: holds the pattern.
  - `bitcnt`: `$clog2(WIDTH+1)` bits wide; bits still to send.
  - `phase`: 8 bits; counts the clocks within the current bit.
- FSM states: IDLE, CLEAR, SEND, FINISH.
- IDLE:
  - `busy`=0, `n`=0, `strobe`=0, `clr`=0.
  - If `load`=1: set `shreg`<=`data` and `bitcnt`<=WIDTH, then go to CLEAR.
- CLEAR (1 cycle):
  - `clr`=1, `busy`=1.
  - Next: SEND with `phase`=0 and `n`=`shreg[WIDTH-1]`.
- SEND:
  - `n` holds `shreg[WIDTH-1]` for all DIV cycles of the bit.
  - `strobe`=1 only while `phase`==1.
  - When `phase`==DIV-1:
    - shift `shreg` left by 1, zero-filled;
    - decrement `bitcnt`;
    - reset `phase` to 0.
  - If `bitcnt` reaches 0, go to FINISH instead of starting another bit.
- FINISH (1 cycle):
  - `done`=1, `busy`=0, `n`=0.
  - Next: IDLE.
- `load` asserted while `busy`=1 (CLEAR or SEND) is ignored, not queued. `data` changes during a frame have no effect.
- `load` asserted during FINISH is also ignored. Back-to-back frames therefore need `load` in IDLE, which gives a minimum gap of one idle cycle.
- Exactly WIDTH strobes are issued per frame. The first bit sent is `data[WIDTH-1]`.

## Timing
- Reset values (whenever `reset`=0, asynchronously):
  - `n`=0, `strobe`=0, `clr`=0, `busy`=0, `done`=0;
  - `shreg`=0, `bitcnt`=0, `phase`=0;
  - state = IDLE.
- Let edge k be the edge where `load` is accepted. Cycle offsets below count from k.
  - k+1: `clr`=1, `busy`=1.
  - Bit i (i=0..WIDTH-1) occupies cycles k+2+i·DIV through k+1+(i+1)·DIV.
  - `n` equals `data[WIDTH-1-i]` throughout bit i.
  - `strobe` is high in cycle k+3+i·DIV.
- Setup and hold around each strobe:
  - `n` is stable ≥1 cycle before `strobe` rises.
  - `n` is stable ≥DIV-2 ≥1 cycles after `strobe` falls.
  - `clr` never overlaps `strobe`.
- `done` is high in cycle k+2+WIDTH·DIV; `busy` falls in that same cycle.
- Frame latency is 1+WIDTH·DIV+1 cycles, which is 74 at the defaults.
- Reset deasserted mid-frame: the sender restarts in IDLE, with no partial strobe, no `clr`, and no `done`.
- Reset asserted while `strobe`=1: the pulse is truncated asynchronously.

## Test plan
- Reset: hold `reset`=0 with `load`=1 and `data`=18'h3FFFF → all outputs stay 0 and no strobe appears. Release → still idle until a `load` is sampled.
- Single frame (defaults), `data`=18'h2D5A3, pulsed for 1 cycle → required response:
  - `clr` at k+1;
  - 18 strobes spaced 4 cycles apart, starting at k+3;
  - `n` sampled at each strobe gives 1,0,1,1,0,1,0,1,0,1,1,0,1,0,0,0,1,1;
  - `done` at k+74.
  - A behavioral LED shifter model then reads 18'h2D5A3.
- Load during busy: second `load` with `data`=18'h00001 at k+20 → ignored, and the model still ends at 18'h2D5A3. A new `load` in IDLE after `done` sends 18'h00001, and the model reads 18'h00001.
- All-zero and all-one patterns: 18'h00000 → 18 strobes with `n`=0 and the model ends at 0. 18'h3FFFF → `n`=1 for the whole SEND window.
- Mid-frame reset: assert `reset`=0 at k+30 for 2 cycles → outputs go to 0 immediately, no `done` follows, and a subsequent `load` runs a full 74-cycle frame.
- Parameter sweep: WIDTH=8, DIV=3, `data`=8'hC5 → strobes at k+3, k+6, …, k+24; `done` at k+26; model reads 8'hC5.

Source files
------------

// File: rtl/led_shift_sender.sv
// led_shift_sender: parallel-to-serial transmitter for the LED shift-register
// display path. A frame is a one-cycle clr pulse followed by WIDTH bits sent
// MSB first, each lasting DIV clocks with a one-cycle strobe in its second clock.
// The frame ends with a one-cycle done pulse.
//   clk1   : system clock, rising edge
//   reset  : asynchronous active-low reset
//   load   : start request, honoured only in idle
//   data   : pattern captured when load is accepted
//   n      : serial data bit (registered)
//   strobe : receiver shift pulse (registered)
//   clr    : receiver clear pulse (registered)
//   busy   : frame in progress (registered)
//   done   : frame-complete pulse (registered)
module led_shift_sender #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DIV   = 4
) (
    input  logic             clk1,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    output logic             n,
    output logic             strobe,
    output logic             clr,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        SEND   = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [BW-1:0]    bitcnt;
    logic [7:0]       phase;

    // Frame sequencer; strobe and done are single-cycle pulses cleared by default
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            shreg  <= '0;
            bitcnt <= '0;
            phase  <= '0;
            n      <= 1'b0;
            strobe <= 1'b0;
            clr    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            strobe <= 1'b0;
            clr    <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    n    <= 1'b0;
                    if (load) begin
                        shreg  <= data;
                        bitcnt <= BW'(WIDTH);
                        clr    <= 1'b1;
                        busy   <= 1'b1;
                        state  <= CLEAR;
                    end
                end
                CLEAR: begin
                    phase <= '0;
                    n     <= shreg[WIDTH-1];
                    state <= SEND;
                end
                SEND: begin
                    if (phase == 8'(DIV - 1)) begin
                        shreg  <= {shreg[WIDTH-2:0], 1'b0};
                        bitcnt <= bitcnt - BW'(1);
                        phase  <= '0;
                        if (bitcnt == BW'(1)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            n     <= 1'b0;
                            state <= FINISH;
                        end else begin
                            // next bit is the one about to become the MSB
                            n <= shreg[WIDTH-2];
                        end
                    end else begin
                        phase  <= phase + 8'd1;
                        // strobe lands in the second clock of each bit
                        strobe <= (phase == 8'd0);
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    n     <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_led_shift_sender.sv
// Directed bench for led_shift_sender: default 18-bit/DIV=4 instance plus an
// 8-bit/DIV=3 instance, each feeding a behavioural LED shifter model.
module tb_led_shift_sender;

    logic        clk1 = 1'b0;
    logic        reset;
    logic        load, load8;
    logic [17:0] data;
    logic [7:0]  data8;
    logic        n, strobe, clr, busy, done;
    logic        n8, strobe8, clr8, busy8, done8;
    logic [17:0] model;
    logic [7:0]  model8;
    int          total = 0;
    int          bad   = 0;

    always #5 clk1 = ~clk1;

    led_shift_sender u_dut (
        .clk1(clk1), .reset(reset), .load(load), .data(data),
        .n(n), .strobe(strobe), .clr(clr), .busy(busy), .done(done)
    );

    led_shift_sender #(.WIDTH(8), .DIV(3)) u_dut8 (
        .clk1(clk1), .reset(reset), .load(load8), .data(data8),
        .n(n8), .strobe(strobe8), .clr(clr8), .busy(busy8), .done(done8)
    );

    // Receiving display shifters
    always @(posedge clk1) begin
        if (clr) model <= '0;
        else if (strobe) model <= {model[16:0], n};
        if (clr8) model8 <= '0;
        else if (strobe8) model8 <= {model8[6:0], n8};
    end

    // One full 18-bit frame; optional extra load (with data d2) at cycle inj
    task automatic run_frame(input logic [17:0] d, input int inj,
                             input logic [17:0] d2, input string tag);
        logic e_n, e_stb, e_clr, e_busy, e_done;
        @(negedge clk1);
        load = 1'b1;
        data = d;
        @(posedge clk1);
        @(negedge clk1);
        load = 1'b0;
        data = ~d;
        for (int c = 1; c <= 74; c++) begin
            e_clr  = (c == 1);
            e_busy = (c < 74);
            e_done = (c == 74);
            e_stb  = (c >= 3) && (c <= 71) && (((c - 3) % 4) == 0);
            e_n    = (c >= 2 && c <= 73) ? d[17 - (c - 2) / 4] : 1'b0;
            total += 5;
            if (clr !== e_clr) begin bad++; $display("FAIL %s clr c=%0d got=%b exp=%b", tag, c, clr, e_clr); end
            if (busy !== e_busy) begin bad++; $display("FAIL %s busy c=%0d got=%b exp=%b", tag, c, busy, e_busy); end
            if (done !== e_done) begin bad++; $display("FAIL %s done c=%0d got=%b exp=%b", tag, c, done, e_done); end
            if (strobe !== e_stb) begin bad++; $display("FAIL %s strobe c=%0d got=%b exp=%b", tag, c, strobe, e_stb); end
            if (n !== e_n) begin bad++; $display("FAIL %s n c=%0d got=%b exp=%b", tag, c, n, e_n); end
            if (c == inj) begin
                load = 1'b1;
                data = d2;
            end else begin
                load = 1'b0;
            end
            if (c < 74) @(negedge clk1);
        end
        total++;
        if (model !== d) begin bad++; $display("FAIL %s model got=%h exp=%h", tag, model, d); end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        load  = 1'b1;
        data  = 18'h3FFFF;
        load8 = 1'b1;
        data8 = 8'hFF;
        repeat (5) begin
            @(negedge clk1);
            total += 2;
            if ({n, strobe, clr, busy, done} !== 5'b0) begin bad++; $display("FAIL reset_hold got=%b exp=00000", {n, strobe, clr, busy, done}); end
            if ({n8, strobe8, clr8, busy8, done8} !== 5'b0) begin bad++; $display("FAIL reset_hold8 got=%b exp=00000", {n8, strobe8, clr8, busy8, done8}); end
        end
        load  = 1'b0;
        load8 = 1'b0;
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk1);
            total++;
            if ({n, strobe, clr, busy, done} !== 5'b0) begin bad++; $display("FAIL reset_release got=%b exp=00000", {n, strobe, clr, busy, done}); end
        end
    endtask

    task automatic test_single();
        run_frame(18'h2D5A3, 0, 18'h0, "single");
    endtask

    task automatic test_load_busy();
        run_frame(18'h2D5A3, 20, 18'h00001, "busy_load");
        run_frame(18'h00001, 0, 18'h0, "after_busy");
    endtask

    task automatic test_patterns();
        run_frame(18'h00000, 0, 18'h0, "zeros");
        run_frame(18'h3FFFF, 0, 18'h0, "ones");
    endtask

    // Reset lands in cycle 31, while a strobe is high
    task automatic test_midreset();
        @(negedge clk1);
        load = 1'b1;
        data = 18'h3FFFF;
        @(posedge clk1);
        @(negedge clk1);
        load = 1'b0;
        repeat (30) @(negedge clk1);
        total++;
        if (strobe !== 1'b1) begin bad++; $display("FAIL midreset_pre strobe got=%b exp=1", strobe); end
        reset = 1'b0;
        #1;
        total++;
        if ({n, strobe, clr, busy, done} !== 5'b0) begin bad++; $display("FAIL midreset_async got=%b exp=00000", {n, strobe, clr, busy, done}); end
        @(negedge clk1);
        @(negedge clk1);
        reset = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk1);
            total++;
            if ({strobe, clr, busy, done} !== 4'b0) begin bad++; $display("FAIL midreset_after c=%0d got=%b exp=0000", c, {strobe, clr, busy, done}); end
        end
        run_frame(18'h2D5A3, 0, 18'h0, "post_reset");
    endtask

    task automatic test_sweep();
        logic e_n, e_stb, e_clr, e_busy, e_done;
        @(negedge clk1);
        load8 = 1'b1;
        data8 = 8'hC5;
        @(posedge clk1);
        @(negedge clk1);
        load8 = 1'b0;
        data8 = 8'h00;
        for (int c = 1; c <= 26; c++) begin
            e_clr  = (c == 1);
            e_busy = (c < 26);
            e_done = (c == 26);
            e_stb  = (c >= 3) && (c <= 24) && (((c - 3) % 3) == 0);
            e_n    = (c >= 2 && c <= 25) ? data8_ref(7 - (c - 2) / 3) : 1'b0;
            total += 5;
            if (clr8 !== e_clr) begin bad++; $display("FAIL sweep clr c=%0d got=%b exp=%b", c, clr8, e_clr); end
            if (busy8 !== e_busy) begin bad++; $display("FAIL sweep busy c=%0d got=%b exp=%b", c, busy8, e_busy); end
            if (done8 !== e_done) begin bad++; $display("FAIL sweep done c=%0d got=%b exp=%b", c, done8, e_done); end
            if (strobe8 !== e_stb) begin bad++; $display("FAIL sweep strobe c=%0d got=%b exp=%b", c, strobe8, e_stb); end
            if (n8 !== e_n) begin bad++; $display("FAIL sweep n c=%0d got=%b exp=%b", c, n8, e_n); end
            if (c < 26) @(negedge clk1);
        end
        total++;
        if (model8 !== 8'hC5) begin bad++; $display("FAIL sweep model got=%h exp=c5", model8); end
    endtask

    function automatic logic data8_ref(input int idx);
        logic [7:0] v;
        v = 8'hC5;
        return v[idx];
    endfunction

    initial begin
        load  = 1'b0;
        load8 = 1'b0;
        data  = '0;
        data8 = '0;
        test_reset();
        test_single();
        test_load_busy();
        test_patterns();
        test_midreset();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
